// File: rtl/spi_led_pkg.sv
// -----------------------------------------------------------------------------
// spi_led_pkg
// Shared types and constants for the APA102-style LED strip driver.
//   state_t          : frame sequencer states
//   START_WORD       : 32-bit start frame (all zeros)
//   END_WORD         : 32-bit end frame (all ones)
//   PIXEL_HDR        : 3-bit marker in front of the brightness field
//   COLOR_*          : {R,G,B} values used when LED_CHASE_COLOR_CYCLE_EN is defined
//   make_pixel_word  : builds one 32-bit pixel word from brightness and {R,G,B}
// -----------------------------------------------------------------------------
package spi_led_pkg;

    typedef enum logic [1:0] {
        GAP   = 2'd0,
        START = 2'd1,
        PIXEL = 2'd2,
        END   = 2'd3
    } state_t;

    localparam logic [31:0] START_WORD = 32'h0000_0000;
    localparam logic [31:0] END_WORD   = 32'hFFFF_FFFF;
    localparam logic [2:0]  PIXEL_HDR  = 3'b111;

    localparam logic [23:0] COLOR_RED   = 24'hFF0000;
    localparam logic [23:0] COLOR_GREEN = 24'h00FF00;
    localparam logic [23:0] COLOR_BLUE  = 24'h0000FF;

    // The strip expects B,G,R order on the wire while colours are held as {R,G,B}.
    function automatic logic [31:0] make_pixel_word(input logic [4:0]  bright,
                                                    input logic [23:0] rgb);
        return {PIXEL_HDR, bright, rgb[7:0], rgb[15:8], rgb[23:16]};
    endfunction

endpackage

// File: rtl/spi_led_if.sv
// -----------------------------------------------------------------------------
// spi_led_if
// Word-level link between the frame sequencer and the serial shifter.
//   load      : sequencer -> shifter, load word and start shifting it (1 cycle)
//   word      : sequencer -> shifter, 32-bit word, MSB sent first
//   word_done : shifter -> sequencer, strobe on the cycle whose edge ends the
//               final sck-high phase of the current word
//   mosi, sck : shifter outputs toward the strip pins
// -----------------------------------------------------------------------------
interface spi_led_if;
    logic        load;
    logic [31:0] word;
    logic        word_done;
    logic        mosi;
    logic        sck;

    modport master (output load, output word, input word_done, input mosi, input sck);
    modport slave  (input load, input word, output word_done, output mosi, output sck);
endinterface

// File: rtl/spi_shift_tx.sv
// -----------------------------------------------------------------------------
// spi_shift_tx
// Serialises 32-bit words onto mosi/sck (SPI mode 0). Each bit occupies
// 2*CLK_DIV cycles: CLK_DIV cycles with sck low, then CLK_DIV with sck high.
// mosi changes only at the start of a bit slot.
// Ports:
//   clk  : system clock
//   srst : synchronous active-high reset
//   bus  : spi_led_if.slave (load/word in, word_done/mosi/sck out)
// A load on the word_done cycle starts the next word with no idle slot; with
// no load the shifter idles with sck and mosi low.
// -----------------------------------------------------------------------------
module spi_shift_tx #(
    parameter int CLK_DIV = 4
) (
    input  logic      clk,
    input  logic      srst,
    spi_led_if.slave  bus
);
    localparam int             DW       = $clog2(CLK_DIV) + 1;
    localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);

    logic [31:0]   r_shift;
    logic [DW-1:0] r_div;
    logic [4:0]    r_bit;
    logic          r_busy;
    logic          r_sck;
    logic          r_mosi;
    logic          w_div_end;

    assign w_div_end     = (r_div == DIV_LAST);
    assign bus.word_done = r_busy && r_sck && w_div_end && (r_bit == 5'd31);
    assign bus.mosi      = r_mosi;
    assign bus.sck       = r_sck;

    always_ff @(posedge clk) begin
        if (srst) begin
            r_shift <= '0;
            r_div   <= '0;
            r_bit   <= '0;
            r_busy  <= 1'b0;
            r_sck   <= 1'b0;
            r_mosi  <= 1'b0;
        end else if (bus.load) begin
            r_shift <= bus.word;
            r_mosi  <= bus.word[31];
            r_div   <= '0;
            r_bit   <= '0;
            r_sck   <= 1'b0;
            r_busy  <= 1'b1;
        end else if (r_busy) begin
            if (w_div_end) begin
                r_div <= '0;
                if (!r_sck) begin
                    r_sck <= 1'b1;
                end else begin
                    // End of the high phase closes the bit slot.
                    r_sck <= 1'b0;
                    if (r_bit == 5'd31) begin
                        r_busy <= 1'b0;
                        r_mosi <= 1'b0;
                    end else begin
                        r_bit   <= r_bit + 5'd1;
                        r_shift <= {r_shift[30:0], 1'b0};
                        r_mosi  <= r_shift[30];
                    end
                end
            end else begin
                r_div <= r_div + DW'(1);
            end
        end
    end

endmodule

// File: rtl/spi_led_strip_top.sv
// -----------------------------------------------------------------------------
// spi_led_strip_top
// Self-running APA102-style LED strip driver: repeatedly sends a start frame,
// NUM_LEDS pixel words and an end frame, separated by FRAME_GAP idle cycles.
// One lit pixel moves one position per frame.
// Ports:
//   CLK      : system clock
//   my_reset : synchronous active-high reset
//   mosi/sck : strip data/clock (mode 0, MSB first, sck idles low)
//   led0     : high while a frame is being transmitted
//   led1     : toggles at the end of every frame
//   led2     : toggles whenever the lit position wraps back to 0
// Optional macro LED_CHASE_COLOR_CYCLE_EN: lit colour steps red -> green ->
// blue on every position wrap instead of using COLOR.
// -----------------------------------------------------------------------------
module spi_led_strip_top
    import spi_led_pkg::*;
#(
    parameter int          NUM_LEDS   = 8,
    parameter int          CLK_DIV    = 4,
    parameter int          FRAME_GAP  = 1000,
    parameter logic [4:0]  BRIGHTNESS = 5'h1F,
    parameter logic [23:0] COLOR      = 24'hFFFFFF
) (
    input  logic CLK,
    input  logic my_reset,
    output logic mosi,
    output logic sck,
    output logic led0,
    output logic led1,
    output logic led2
);
    localparam int            PW       = $clog2(NUM_LEDS);
    localparam logic [PW-1:0] PIX_LAST = PW'(NUM_LEDS - 1);

    spi_led_if w_bus ();

    spi_shift_tx #(.CLK_DIV(CLK_DIV)) u_tx (
        .clk  (CLK),
        .srst (my_reset),
        .bus  (w_bus)
    );

    state_t        r_state,   w_state_next;
    logic [31:0]   r_gap_cnt, w_gap_next;
    logic [PW-1:0] r_pix,     w_pix_next;
    logic [PW-1:0] r_pos;
    logic          r_led0, r_led1, r_led2;
    logic          w_load, w_frame_end;
    logic [31:0]   w_word;
    logic [23:0]   w_lit;

`ifdef LED_CHASE_COLOR_CYCLE_EN
    logic [1:0] r_color_idx;

    always_ff @(posedge CLK) begin
        if (my_reset) begin
            r_color_idx <= 2'd0;
        end else if (w_frame_end && (r_pos == PIX_LAST)) begin
            r_color_idx <= (r_color_idx == 2'd2) ? 2'd0 : r_color_idx + 2'd1;
        end
    end

    always_comb begin
        case (r_color_idx)
            2'd0:    w_lit = COLOR_RED;
            2'd1:    w_lit = COLOR_GREEN;
            default: w_lit = COLOR_BLUE;
        endcase
    end
`else
    assign w_lit = COLOR;
`endif

    // Sequencer: advances on word_done and requests the following word in the
    // same cycle so words run back to back.
    always_comb begin
        w_state_next = r_state;
        w_gap_next   = r_gap_cnt;
        w_pix_next   = r_pix;
        w_load       = 1'b0;
        w_frame_end  = 1'b0;
        case (r_state)
            GAP: begin
                if (r_gap_cnt == 32'd0) begin
                    w_state_next = START;
                    w_load       = 1'b1;
                end else begin
                    w_gap_next = r_gap_cnt - 32'd1;
                end
            end
            START: begin
                if (w_bus.word_done) begin
                    w_state_next = PIXEL;
                    w_pix_next   = '0;
                    w_load       = 1'b1;
                end
            end
            PIXEL: begin
                if (w_bus.word_done) begin
                    w_load = 1'b1;
                    if (r_pix == PIX_LAST) begin
                        w_state_next = END;
                    end else begin
                        w_pix_next = r_pix + PW'(1);
                    end
                end
            end
            END: begin
                if (w_bus.word_done) begin
                    w_state_next = GAP;
                    w_gap_next   = 32'(FRAME_GAP - 1);
                    w_frame_end  = 1'b1;
                end
            end
            default: w_state_next = GAP;
        endcase
    end

    // Word mux keyed on the state/pixel being entered, i.e. the word to load.
    always_comb begin
        case (w_state_next)
            START:   w_word = START_WORD;
            PIXEL:   w_word = make_pixel_word(BRIGHTNESS, (w_pix_next == r_pos) ? w_lit : 24'h0);
            END:     w_word = END_WORD;
            default: w_word = 32'h0;
        endcase
    end

    assign w_bus.load = w_load;
    assign w_bus.word = w_word;

    always_ff @(posedge CLK) begin
        if (my_reset) begin
            r_state   <= GAP;
            r_gap_cnt <= '0;
            r_pix     <= '0;
            r_pos     <= '0;
            r_led0    <= 1'b0;
            r_led1    <= 1'b0;
            r_led2    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_gap_cnt <= w_gap_next;
            r_pix     <= w_pix_next;
            r_led0    <= (w_state_next != GAP);
            if (w_frame_end) begin
                r_led1 <= ~r_led1;
                if (r_pos == PIX_LAST) begin
                    r_pos  <= '0;
                    r_led2 <= ~r_led2;
                end else begin
                    r_pos <= r_pos + PW'(1);
                end
            end
        end
    end

    assign mosi = w_bus.mosi;
    assign sck  = w_bus.sck;
    assign led0 = r_led0;
    assign led1 = r_led1;
    assign led2 = r_led2;

endmodule

// File: tb/tb_spi_led_strip_top.sv
// -----------------------------------------------------------------------------
// tb_spi_led_strip_top
// Scoreboard bench for spi_led_strip_top with default parameters. Expected
// frame words are queued when a frame is due (reset release / previous frame
// end); bits captured on sck rising edges are compared against them once the
// frame completes. Honours LED_CHASE_COLOR_CYCLE_EN for the expected colour.
// -----------------------------------------------------------------------------
module tb_spi_led_strip_top;

    localparam int NUM_LEDS    = 8;
    localparam int CLK_DIV     = 4;
    localparam int FRAME_GAP   = 1000;
    localparam int FRAME_WORDS = NUM_LEDS + 2;
    localparam int FRAME_BITS  = 32 * FRAME_WORDS;
    localparam int FRAME_CYC   = FRAME_BITS * 2 * CLK_DIV;

    logic CLK = 1'b0;
    logic my_reset = 1'b1;
    logic mosi, sck, led0, led1, led2;

    always #5 CLK = ~CLK;

    spi_led_strip_top dut (
        .CLK      (CLK),
        .my_reset (my_reset),
        .mosi     (mosi),
        .sck      (sck),
        .led0     (led0),
        .led1     (led1),
        .led2     (led2)
    );

    // Probe bundle on the strip pins.
    spi_led_if u_mon ();
    assign u_mon.mosi      = mosi;
    assign u_mon.sck       = sck;
    assign u_mon.load      = 1'b0;
    assign u_mon.word      = 32'h0;
    assign u_mon.word_done = 1'b0;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] exp_q[$];
    logic        cap_q[$];
    logic        sck_prev   = 1'b0;
    logic        led0_prev  = 1'b0;
    int          hi_len     = 0;
    int          lo_len     = 0;
    int          last_hi    = 0;
    int          last_lo    = 0;
    int          frames_done = 0;

    // One cycle step: sample on the falling edge and record bits/run lengths.
    task automatic tick();
        @(negedge CLK);
        if (my_reset) begin
            cap_q.delete();
            sck_prev    = 1'b0;
            led0_prev   = 1'b0;
            hi_len      = 0;
            lo_len      = 0;
            frames_done = 0;
        end else begin
            if (u_mon.sck && !sck_prev) cap_q.push_back(u_mon.mosi);
            sck_prev = u_mon.sck;
            if (led0 && !led0_prev) begin
                last_lo = lo_len;
                hi_len  = 0;
            end
            if (!led0 && led0_prev) begin
                last_hi = hi_len;
                lo_len  = 0;
                frames_done++;
            end
            if (led0) hi_len++;
            else      lo_len++;
            led0_prev = led0;
        end
    endtask

    // Expected words of frame k (1-based count since reset).
    task automatic push_frame(input int k);
        logic [23:0] c;
        logic [31:0] lit;
        int          lp;
        lp = (k - 1) % NUM_LEDS;
`ifdef LED_CHASE_COLOR_CYCLE_EN
        case (((k - 1) / NUM_LEDS) % 3)
            0:       c = 24'hFF0000;
            1:       c = 24'h00FF00;
            default: c = 24'h0000FF;
        endcase
`else
        c = 24'hFFFFFF;
`endif
        lit = {3'b111, 5'h1F, c[7:0], c[15:8], c[23:16]};
        exp_q.push_back(32'h0000_0000);
        for (int p = 0; p < NUM_LEDS; p++)
            exp_q.push_back((p == lp) ? lit : 32'hFF00_0000);
        exp_q.push_back(32'hFFFF_FFFF);
    endtask

    task automatic wait_frames(input int k);
        int budget;
        budget = 2 * (FRAME_CYC + FRAME_GAP) + 100;
        while (frames_done < k && budget > 0) begin
            tick();
            budget--;
        end
        if (frames_done < k) begin
            compared++;
            mismatched++;
            $display("FAIL frame_timeout: got %0d frames required %0d", frames_done, k);
        end
    endtask

    task automatic test_reset();
        int n;
        my_reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            compared++;
            if ({sck, mosi, led0, led1, led2} !== 5'b0) begin
                mismatched++;
                $display("FAIL reset_outputs: got %b required 00000 (cycle %0d)", {sck, mosi, led0, led1, led2}, i);
            end
        end
        my_reset = 1'b0;
        push_frame(1);
        tick();
        compared++;
        if ({led0, sck, mosi} !== 3'b100) begin
            mismatched++;
            $display("FAIL first_cycle_after_reset: got led0/sck/mosi=%b required 100", {led0, sck, mosi});
        end
        n = 0;
        while (sck !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        compared++;
        if (n != CLK_DIV) begin
            mismatched++;
            $display("FAIL first_sck_rise: got %0d cycles required %0d", n, CLK_DIV);
        end
        $display("reset: first sck rise after %0d cycles", n);
    endtask

    task automatic test_frame_data(input int k);
        logic [31:0] got;
        logic [31:0] exp;
        wait_frames(k);
        compared++;
        if (cap_q.size() != FRAME_BITS) begin
            mismatched++;
            $display("FAIL frame%0d_bit_count: got %0d required %0d", k, cap_q.size(), FRAME_BITS);
        end
        for (int w = 0; w < FRAME_WORDS; w++) begin
            got = 32'h0;
            for (int b = 0; b < 32; b++) begin
                if (cap_q.size() > 0) got = {got[30:0], cap_q.pop_front()};
                else                  got = {got[30:0], 1'bx};
            end
            if (exp_q.size() > 0) exp = exp_q.pop_front();
            else                  exp = 32'hxxxx_xxxx;
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("FAIL frame%0d_word%0d: got %h required %h", k, w, got, exp);
            end
        end
        cap_q.delete();
        compared++;
        if (last_hi != FRAME_CYC) begin
            mismatched++;
            $display("FAIL frame%0d_led0_high: got %0d required %0d", k, last_hi, FRAME_CYC);
        end
        if (k > 1) begin
            compared++;
            if (last_lo != FRAME_GAP) begin
                mismatched++;
                $display("FAIL frame%0d_gap: got %0d required %0d", k, last_lo, FRAME_GAP);
            end
        end
        compared++;
        if (led1 !== 1'(k % 2)) begin
            mismatched++;
            $display("FAIL frame%0d_led1: got %b required %0d", k, led1, k % 2);
        end
        compared++;
        if (led2 !== 1'((k / NUM_LEDS) % 2)) begin
            mismatched++;
            $display("FAIL frame%0d_led2: got %b required %0d", k, led2, (k / NUM_LEDS) % 2);
        end
        $display("frame %0d: lit pixel %0d, led0 high %0d, gap %0d, led1=%b led2=%b",
                 k, (k - 1) % NUM_LEDS, last_hi, last_lo, led1, led2);
        push_frame(k + 1);
    endtask

    task automatic test_chase();
        for (int k = 2; k <= 2 * NUM_LEDS + 1; k++) test_frame_data(k);
    endtask

    task automatic test_reset_mid_frame();
        int budget;
        budget = FRAME_CYC + FRAME_GAP + 100;
        while (cap_q.size() < 100 && budget > 0) begin
            tick();
            budget--;
        end
        compared++;
        if (cap_q.size() < 100) begin
            mismatched++;
            $display("FAIL mid_frame_reach_bit100: got %0d bits required 100", cap_q.size());
        end
        my_reset = 1'b1;
        tick();
        compared++;
        if ({sck, mosi, led0, led1, led2} !== 5'b0) begin
            mismatched++;
            $display("FAIL mid_frame_reset: got %b required 00000", {sck, mosi, led0, led1, led2});
        end
        $display("mid-frame reset at bit 100: outputs %b", {sck, mosi, led0, led1, led2});
        for (int i = 0; i < 3; i++) tick();
        exp_q.delete();
        my_reset = 1'b0;
        push_frame(1);
        test_frame_data(1);
    endtask

    initial begin
        test_reset();
        test_frame_data(1);
        test_chase();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
